// File: rtl/sa_pe_pkg.sv
// rtl/sa_pe_pkg.sv - shared types and constants for the PE partial-sum path
package sa_pe_pkg;

   localparam int PSUM_W    = 16;
   localparam int MAC_CNT_W = 8;

   typedef logic [PSUM_W-1:0] psum_t;

   typedef enum logic {
      SHD_EMPTY = 1'b0,
      SHD_FULL  = 1'b1
   } shd_state_e;

   function automatic int unsigned cnt_sat_val(input int w);
      return (32'd1 << w) - 32'd1;
   endfunction

   localparam int unsigned MAC_CNT_SAT = cnt_sat_val(MAC_CNT_W);

endpackage

// File: rtl/sa_psum_shadow.sv
// rtl/sa_psum_shadow.sv - shadow psum register with drain FSM, overwrite flag and scan path
module sa_psum_shadow
   import sa_pe_pkg::*;
#(
   parameter int OC_W = PSUM_W
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_swap_ld,
   input  logic [OC_W-1:0] i_swap_val,
   input  logic            i_shift,
   input  logic [OC_W-1:0] i_scan_in,
   output logic [OC_W-1:0] o_scan_out,
   output logic            o_shd_valid,
   output logic            o_ovr
);

   shd_state_e      state_q, state_d;
   logic [OC_W-1:0] shd_q;
   logic            ovr_q;
   logic            ovr_set;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= SHD_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // A swap always takes the shadow, even when a shift drains it in the same cycle.
   always_comb begin
      state_d = state_q;
      ovr_set = 1'b0;
      if (i_swap_ld) begin
         state_d = SHD_FULL;
         ovr_set = (state_q == SHD_FULL) && !i_shift;
      end else if (i_shift) begin
         state_d = SHD_EMPTY;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         shd_q <= '0;
         ovr_q <= 1'b0;
      end else begin
         if (i_swap_ld) begin
            shd_q <= i_swap_val;
         end else if (i_shift) begin
            shd_q <= i_scan_in;
         end
         if (ovr_set) begin
            ovr_q <= 1'b1;
         end
      end
   end

   assign o_scan_out  = shd_q;
   assign o_shd_valid = (state_q == SHD_FULL);
   assign o_ovr       = ovr_q;

endmodule

// File: rtl/sa_psum_accum.sv
// rtl/sa_psum_accum.sv - PE partial-sum accumulator with context swap into a drainable shadow
module sa_psum_accum
   import sa_pe_pkg::*;
#(
   parameter int OC_W  = PSUM_W,
   parameter int CNT_W = MAC_CNT_W
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [OC_W-1:0]  i_sum,
   output logic [OC_W-1:0]  o_c,
   input  logic             i_pipe_en,
   input  logic             i_acc_en,
   input  logic             i_swap,
   input  logic             i_preload,
   input  logic [OC_W-1:0]  i_preload_val,
   input  logic             i_shift,
   input  logic [OC_W-1:0]  i_scan_in,
   output logic [OC_W-1:0]  o_scan_out,
   output logic             o_shd_valid,
   output logic [CNT_W-1:0] o_mac_cnt,
   output logic             o_ovr
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_sat_val(CNT_W));

   logic [OC_W-1:0]  acc_q;
   logic [CNT_W-1:0] cnt_q;
   logic             swap_ld;
   logic [OC_W-1:0]  swap_val;

   assign swap_ld  = i_pipe_en && i_swap;
   // The product arriving with the swap still belongs to the finishing context.
   assign swap_val = i_acc_en ? i_sum : acc_q;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         acc_q <= '0;
         cnt_q <= '0;
      end else if (i_pipe_en) begin
         if (i_swap) begin
            acc_q <= i_preload ? i_preload_val : '0;
            cnt_q <= '0;
         end else if (i_acc_en) begin
            acc_q <= i_sum;
            if (cnt_q != CNT_MAX) begin
               cnt_q <= cnt_q + 1'b1;
            end
         end
      end
   end

   sa_psum_shadow #(
      .OC_W (OC_W)
   ) u_shadow (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_swap_ld   (swap_ld),
      .i_swap_val  (swap_val),
      .i_shift     (i_shift),
      .i_scan_in   (i_scan_in),
      .o_scan_out  (o_scan_out),
      .o_shd_valid (o_shd_valid),
      .o_ovr       (o_ovr)
   );

   assign o_c       = acc_q;
   assign o_mac_cnt = cnt_q;

endmodule

// File: tb/tb_sa_psum_accum.sv
// tb/tb_sa_psum_accum.sv - directed and random checks of sa_psum_accum against a reference model
module tb_sa_psum_accum;
   import sa_pe_pkg::*;

   logic        clk = 1'b0;
   logic        rst, pipe_en, acc_en, swap, preload, shift;
   psum_t       sum, preload_val, scan_in;
   psum_t       c_a, so_a, c_b, so_b;
   logic        v_a, ovr_a, v_b, ovr_b;
   logic [7:0]  cnt_a;
   logic [1:0]  cnt_b;

   int total = 0;
   int bad   = 0;

   int unsigned m_acc, m_shd, m_cnt_a, m_cnt_b;
   bit          m_valid, m_ovr;

   always #5 clk = ~clk;

   sa_psum_accum #(.OC_W(16), .CNT_W(8)) dut_a (
      .i_clk(clk), .i_rst(rst), .i_sum(sum), .o_c(c_a), .i_pipe_en(pipe_en),
      .i_acc_en(acc_en), .i_swap(swap), .i_preload(preload), .i_preload_val(preload_val),
      .i_shift(shift), .i_scan_in(scan_in), .o_scan_out(so_a), .o_shd_valid(v_a),
      .o_mac_cnt(cnt_a), .o_ovr(ovr_a)
   );

   sa_psum_accum #(.OC_W(16), .CNT_W(2)) dut_b (
      .i_clk(clk), .i_rst(rst), .i_sum(sum), .o_c(c_b), .i_pipe_en(pipe_en),
      .i_acc_en(acc_en), .i_swap(swap), .i_preload(preload), .i_preload_val(preload_val),
      .i_shift(shift), .i_scan_in(scan_in), .o_scan_out(so_b), .o_shd_valid(v_b),
      .o_mac_cnt(cnt_b), .o_ovr(ovr_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_model();
      chk("a_o_c",      32'(c_a),   m_acc);
      chk("a_scan_out", 32'(so_a),  m_shd);
      chk("a_valid",    32'(v_a),   32'(m_valid));
      chk("a_cnt",      32'(cnt_a), m_cnt_a);
      chk("a_ovr",      32'(ovr_a), 32'(m_ovr));
      chk("b_o_c",      32'(c_b),   m_acc);
      chk("b_scan_out", 32'(so_b),  m_shd);
      chk("b_valid",    32'(v_b),   32'(m_valid));
      chk("b_cnt",      32'(cnt_b), m_cnt_b);
      chk("b_ovr",      32'(ovr_b), 32'(m_ovr));
   endtask

   // Reference: apply the block's cycle rules to the pre-edge state.
   task automatic model_step();
      if (rst) begin
         m_acc = 0; m_shd = 0; m_cnt_a = 0; m_cnt_b = 0; m_valid = 0; m_ovr = 0;
      end else begin
         if (pipe_en && swap) begin
            if (m_valid && !shift) m_ovr = 1;
            m_shd   = acc_en ? 32'(sum) : m_acc;
            m_valid = 1;
            m_acc   = preload ? 32'(preload_val) : 0;
            m_cnt_a = 0;
            m_cnt_b = 0;
         end else begin
            if (shift) begin
               m_shd   = 32'(scan_in);
               m_valid = 0;
            end
            if (pipe_en && acc_en) begin
               m_acc   = 32'(sum);
               m_cnt_a = (m_cnt_a + 1 > 255) ? 255 : m_cnt_a + 1;
               m_cnt_b = (m_cnt_b + 1 > 3) ? 3 : m_cnt_b + 1;
            end
         end
      end
   endtask

   task automatic cyc(input bit r, input bit pe, input bit ae, input bit sw, input bit pl,
                      input psum_t pv, input bit sh, input psum_t si, input psum_t s);
      rst = r; pipe_en = pe; acc_en = ae; swap = sw; preload = pl;
      preload_val = pv; shift = sh; scan_in = si; sum = s;
      #1;
      chk("pre_edge_scan_out", 32'(so_a), m_shd);
      @(posedge clk);
      model_step();
      #1;
      chk_model();
   endtask

   task automatic acc(input psum_t s);
      cyc(0, 1, 1, 0, 0, 16'h0, 0, 16'h0, s);
   endtask

   task automatic idle();
      cyc(0, 1, 0, 0, 0, 16'h0, 0, 16'h0, 16'h0);
   endtask

   initial begin
      m_acc = 0; m_shd = 0; m_cnt_a = 0; m_cnt_b = 0; m_valid = 0; m_ovr = 0;
      rst = 1; pipe_en = 0; acc_en = 0; swap = 0; preload = 0;
      preload_val = '0; shift = 0; scan_in = '0; sum = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_o_c", 32'(c_a), 0);
      chk("reset_valid", 32'(v_a), 0);
      chk("reset_cnt", 32'(cnt_a), 0);
      chk("reset_ovr", 32'(ovr_a), 0);

      // Accumulate 5,7,9 with one-cycle visibility lag
      acc(16'd5);  chk("t1_c5", 32'(c_a), 5);
      acc(16'd7);  chk("t1_c7", 32'(c_a), 7);
      acc(16'd9);  chk("t1_c9", 32'(c_a), 9);
      chk("t1_cnt3", 32'(cnt_a), 3);

      // Swap with final product and preload
      acc(16'd20);
      cyc(0, 1, 1, 1, 1, 16'd100, 0, 16'h0, 16'd23);
      chk("t2_shd", 32'(so_a), 23);
      chk("t2_c", 32'(c_a), 100);
      chk("t2_cnt", 32'(cnt_a), 0);
      chk("t2_valid", 32'(v_a), 1);

      // Overwrite of an undrained shadow
      acc(16'd4);
      cyc(0, 1, 0, 1, 0, 16'h0, 0, 16'h0, 16'h0);
      chk("t3_shd", 32'(so_a), 4);
      chk("t3_ovr", 32'(ovr_a), 1);
      idle(); idle();
      chk("t3_ovr_sticky", 32'(ovr_a), 1);

      // Swap and shift together
      cyc(1, 0, 0, 0, 0, 16'h0, 0, 16'h0, 16'h0);
      acc(16'd23);
      cyc(0, 1, 0, 1, 0, 16'h0, 0, 16'h0, 16'h0);
      acc(16'd40);
      cyc(0, 1, 0, 1, 0, 16'h0, 1, 16'd55, 16'h0);
      chk("t4_shd", 32'(so_a), 40);
      chk("t4_valid", 32'(v_a), 1);
      chk("t4_ovr", 32'(ovr_a), 0);

      // Pipeline stall: swap and accumulate ignored, scan still shifts
      acc(16'd11);
      cyc(0, 0, 1, 1, 1, 16'd3, 0, 16'h0, 16'd999);
      chk("t5_c_hold", 32'(c_a), 11);
      chk("t5_cnt_hold", 32'(cnt_a), 1);
      cyc(0, 0, 0, 0, 0, 16'h0, 1, 16'hBEEF, 16'h0);
      chk("t5_shift", 32'(so_a), 32'hBEEF);
      chk("t5_valid", 32'(v_a), 0);

      // Counter saturation (narrow instance) and accumulator wrap
      repeat (5) acc(16'd1);
      chk("t6_cnt_sat", 32'(cnt_b), 3);
      acc(16'hFFFF);
      acc(16'(c_a + 16'd2));
      chk("t6_wrap", 32'(c_a), 1);

      // Preload without swap is inert
      cyc(0, 1, 1, 0, 1, 16'd500, 0, 16'h0, 16'd8);
      chk("preload_noswap", 32'(c_a), 8);

      // Mid-context reset
      acc(16'd77);
      cyc(0, 1, 0, 1, 0, 16'h0, 0, 16'h0, 16'h0);
      acc(16'd77);
      cyc(1, 1, 1, 1, 1, 16'd9, 1, 16'd6, 16'd5);
      chk("rst_c", 32'(c_a), 0);
      chk("rst_valid", 32'(v_a), 0);
      chk("rst_shd", 32'(so_a), 0);

      // Random traffic; i_sum follows the adder relation o_c + product
      for (int i = 0; i < 400; i++) begin
         cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) != 0),
             ($urandom_range(0, 3) != 0), ($urandom_range(0, 5) == 0),
             $urandom_range(0, 1), psum_t'($urandom), ($urandom_range(0, 3) == 0),
             psum_t'($urandom), psum_t'(m_acc + $urandom_range(0, 1023)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
